tnn_sample_sequencer: RTL

// - Upstream feeder and result collector for one evolved TNN comparator node (combinational, 5 x 3-bit operands a..e, 1-bit out).
// - Accepts a serial stream of 3-bit quantised features over valid/ready and assembles each group of NUM_FEAT features into one sample.
// - Drives the sample as registered operands into the node, captures the node output and returns it over valid/ready.
// - Computes the exact decision alongside the node output and counts disagreements, giving in-system error monitoring for approximate nodes.

---
 rtl/tnn_pkg.sv | 21 ++
 rtl/tnn_golden_cmp.sv | 25 ++
 rtl/tnn_sample_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tnn_pkg.sv
// Shared definitions for the TNN sample sequencer slice.
//   FEAT_W      - width of one quantised feature / node operand
//   NUM_FEAT    - features per sample (node operands a..e)
//   CNT_W       - width of the sample and mismatch counters
//   feat_t      - one feature value
//   seq_state_e - sequencer FSM states
package tnn_pkg;

    localparam int FEAT_W   = 3;
    localparam int NUM_FEAT = 5;
    localparam int CNT_W    = 16;

    typedef logic [FEAT_W-1:0] feat_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        HOLD    = 2'd2
    } seq_state_e;

endpackage

// File: rtl/tnn_golden_cmp.sv
// Exact reference decision for the comparator node: (a+b) > (c+d+e).
// Sums are widened so nothing is truncated (a+b needs FEAT_W+1 bits,
// c+d+e needs FEAT_W+2 bits).
// Ports:
//   a..e  in  FEAT_W  unsigned operands
//   gt    out 1       1 when a+b is strictly greater than c+d+e
module tnn_golden_cmp #(
    parameter int FEAT_W = tnn_pkg::FEAT_W
) (
    input  logic [FEAT_W-1:0] a,
    input  logic [FEAT_W-1:0] b,
    input  logic [FEAT_W-1:0] c,
    input  logic [FEAT_W-1:0] d,
    input  logic [FEAT_W-1:0] e,
    output logic              gt
);

    logic [FEAT_W:0]   sum_ab;
    logic [FEAT_W+1:0] sum_cde;

    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign sum_cde = {2'b00, c} + {2'b00, d} + {2'b00, e};
    assign gt      = {1'b0, sum_ab} > sum_cde;

endmodule

// File: rtl/tnn_sample_sequencer.sv
// Feeds one combinational TNN comparator node and collects its decisions.
// Features arrive serially over valid/ready; every NUM_FEAT of them form a
// sample that is held on op_a..op_e for one EVAL cycle, after which the node
// output and the exact decision are registered and offered over valid/ready.
// Disagreements between node and exact decision are counted.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   feat_valid/ready/data/last   feature input stream
//   op_a..op_e                   registered operands to the node
//   node_out                     node decision (combinational from op_*)
//   res_valid/ready              result handshake
//   res_node, res_exact          captured node and exact decisions
//   err_frame, err_clr           sticky framing error and its clear
//   sample_cnt                   samples evaluated (wraps)
//   mism_cnt                     node/exact disagreements (saturates)
module tnn_sample_sequencer
    import tnn_pkg::*;
#(
    parameter int FEAT_W   = tnn_pkg::FEAT_W,
    parameter int NUM_FEAT = tnn_pkg::NUM_FEAT,
    parameter int CNT_W    = tnn_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [FEAT_W-1:0] feat_data,
    input  logic              feat_last,
    output logic [FEAT_W-1:0] op_a,
    output logic [FEAT_W-1:0] op_b,
    output logic [FEAT_W-1:0] op_c,
    output logic [FEAT_W-1:0] op_d,
    output logic [FEAT_W-1:0] op_e,
    input  logic              node_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_node,
    output logic              res_exact,
    output logic              err_frame,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  mism_cnt
);

    localparam int IDX_W = $clog2(NUM_FEAT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    seq_state_e state, state_nxt;

    logic [IDX_W-1:0]                 feat_idx;
    logic [NUM_FEAT-1:0][FEAT_W-1:0]  ops;
    logic                             accept;
    logic                             at_last_slot;
    logic                             frame_err;
    logic                             exact;

    assign feat_ready   = (state == COLLECT);
    assign res_valid    = (state == HOLD);
    assign accept       = feat_valid & feat_ready;
    assign at_last_slot = (feat_idx == LAST_IDX);
    // feat_last must coincide exactly with the final slot; early last drops
    // the partial sample, missing last still lets the sample through.
    assign frame_err    = accept & (feat_last ^ at_last_slot);

    assign op_a = ops[0];
    assign op_b = ops[1];
    assign op_c = ops[2];
    assign op_d = ops[3];
    assign op_e = ops[4];

    tnn_golden_cmp #(.FEAT_W(FEAT_W)) u_golden (
        .a  (ops[0]),
        .b  (ops[1]),
        .c  (ops[2]),
        .d  (ops[3]),
        .e  (ops[4]),
        .gt (exact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && at_last_slot) state_nxt = EVAL;
            EVAL:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_idx   <= '0;
            ops        <= '0;
            err_frame  <= 1'b0;
            res_node   <= 1'b0;
            res_exact  <= 1'b0;
            sample_cnt <= '0;
            mism_cnt   <= '0;
        end else begin
            if (accept) begin
                ops[feat_idx] <= feat_data;
                if (at_last_slot || feat_last) feat_idx <= '0;
                else                           feat_idx <= feat_idx + IDX_W'(1);
            end

            // A new framing error beats a simultaneous clear.
            if (frame_err)    err_frame <= 1'b1;
            else if (err_clr) err_frame <= 1'b0;

            if (state == EVAL) begin
                res_node   <= node_out;
                res_exact  <= exact;
                sample_cnt <= sample_cnt + CNT_W'(1);
                if ((node_out != exact) && (mism_cnt != {CNT_W{1'b1}}))
                    mism_cnt <= mism_cnt + CNT_W'(1);
            end
        end
    end

endmodule
